// File: rtl/seq_multiplier_8bit.sv
// seq_multiplier_8bit
//   Sequential shift-add multiplier producing a 2*WIDTH-bit product, one
//   partial-product step per clock. Supports unsigned and two's-complement
//   operands (tc). Sign-magnitude internally: magnitudes are multiplied and
//   the result is negated at the end when the operand signs differ.
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only while idle
//   tc           in   1 = two's-complement operands, sampled with start
//   multiplicand in   operand A [WIDTH-1:0], sampled with start
//   multiplier   in   operand B [WIDTH-1:0], sampled with start
//   product      out  result [2*WIDTH-1:0], held until the next accepted start
//   busy         out  high in RUN and DONE
//   eop          out  one-cycle pulse in DONE
module seq_multiplier_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               eop
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc_step;
  logic [WIDTH-1:0]     mplr_step;
  logic [2*WIDTH-1:0]   mag;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    // One shift-add step; the carry out of the add is shifted into acc MSB.
    sum       = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_step  = sum[WIDTH:1];
    mplr_step = {sum[0], mplr_q[WIDTH-1:1]};
    mag       = {acc_step, mplr_step};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Magnitude of the most negative value still fits as unsigned.
          mcand_d = (tc && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
          mplr_d  = (tc && multiplier[WIDTH-1])   ? (~multiplier + 1'b1)   : multiplier;
          neg_d   = tc && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_step;
        mplr_d = mplr_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          // Product takes the final step's result directly on the exit edge.
          product_d = neg_q ? (~mag + 1'b1) : mag;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q != IDLE);
  assign eop     = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Directed bench for seq_multiplier_8bit. Inputs are driven and outputs
// sampled on the falling edge; "cycle n" is the n-th falling edge after the
// accept edge.
module tb_seq_multiplier_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tc;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        busy;
  logic        eop;

  int unsigned checks;
  int unsigned errors;

  seq_multiplier_8bit #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tc           (tc),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .eop          (eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full operation from idle: accept, 8 RUN cycles, DONE, back to idle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic t,
                        input logic [15:0] exp, input string name);
    int unsigned bad_busy;
    int unsigned bad_eop;
    bad_busy = 0;
    bad_eop  = 0;
    start = 1'b1; tc = t; multiplicand = a; multiplier = b;
    @(posedge clk);
    @(negedge clk);
    // Scramble operands to confirm only latched copies are used.
    start = 1'b0; tc = ~t; multiplicand = 8'h55; multiplier = 8'hAA;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(negedge clk);
      if (busy !== (i <= 9)) bad_busy++;
      if (eop !== (i == 9)) bad_eop++;
      if (i == 9) begin
        checks++;
        if (product !== exp) begin
          errors++;
          $display("FAIL %s product at eop: got %h expected %h", name, product, exp);
        end
      end
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s busy timing: got %0d wrong cycles expected 0", name, bad_busy);
    end
    checks++;
    if (bad_eop != 0) begin
      errors++;
      $display("FAIL %s eop timing: got %0d wrong cycles expected 0", name, bad_eop);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s product hold: got %h expected %h", name, product, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tc = 1'b0; multiplicand = '0; multiplier = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (product !== 16'h0000 || busy !== 1'b0 || eop !== 1'b0) begin
      errors++;
      $display("FAIL reset: got product=%h busy=%b eop=%b expected 0000 0 0",
               product, busy, eop);
    end
  endtask

  task automatic test_unsigned();
    run_op(8'h48, 8'h0B, 1'b0, 16'h0318, "u_72x11");
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ffxff");
    run_op(8'h00, 8'hA5, 1'b0, 16'h0000, "u_0xa5");
    run_op(8'h80, 8'h80, 1'b0, 16'h4000, "u_80x80");
  endtask

  task automatic test_signed();
    run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    run_op(8'h80, 8'h01, 1'b1, 16'hFF80, "s_m128x1");
    run_op(8'h00, 8'hFF, 1'b1, 16'h0000, "s_0xm1");
    run_op(8'h07, 8'hFA, 1'b1, 16'hFFD6, "s_7xm6");
  endtask

  task automatic test_start_ignored();
    int unsigned eops;
    eops = 0;
    start = 1'b1; tc = 1'b0; multiplicand = 8'h48; multiplier = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 3) begin
        start = 1'b1; multiplicand = 8'h02; multiplier = 8'h02;
      end else if (i == 4) begin
        start = 1'b0;
      end
      if (eop === 1'b1) eops++;
    end
    checks++;
    if (eops != 1) begin
      errors++;
      $display("FAIL ignored_start eop count: got %0d expected 1", eops);
    end
    checks++;
    if (product !== 16'h0318) begin
      errors++;
      $display("FAIL ignored_start product: got %h expected 0318", product);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned eop_mask_bad;
    eop_mask_bad = 0;
    start = 1'b1; tc = 1'b0; multiplicand = 8'h03; multiplier = 8'h04;
    @(posedge clk);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (eop !== (i == 9 || i == 19)) eop_mask_bad++;
      if (i == 9) multiplicand = 8'h05;
      if (i == 19) begin
        start = 1'b0;
        checks++;
        if (product !== 16'h0014) begin
          errors++;
          $display("FAIL back_to_back second product: got %h expected 0014", product);
        end
      end
    end
    checks++;
    if (eop_mask_bad != 0) begin
      errors++;
      $display("FAIL back_to_back eop timing: got %0d wrong cycles expected 0", eop_mask_bad);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int unsigned eops;
    eops = 0;
    start = 1'b1; tc = 1'b0; multiplicand = 8'h48; multiplier = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || product !== 16'h0000 || eop !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run state: got busy=%b product=%h eop=%b expected 0 0000 0",
               busy, product, eop);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (eop === 1'b1) eops++;
    end
    checks++;
    if (eops != 0) begin
      errors++;
      $display("FAIL reset_mid_run stray eop: got %0d expected 0", eops);
    end
    run_op(8'h06, 8'h07, 1'b0, 16'h002A, "after_rst_6x7");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
